// File: rtl/video_timing_detector.sv
// rtl/video_timing_detector.sv - recovers pixel position and measures/locks incoming video timing
// Purpose: observes an hsync/vsync/de stream in the pixel clock domain, recovers
// sx/sy, measures line and frame geometry and reports lock against the expected mode.
// Ports:
//   clk_pix, rst         pixel clock, synchronous active-high reset
//   hsync, vsync, de     incoming timing (syncs active-low, de high in active area)
//   de_o, sx, sy         de delayed one clock with aligned recovered position
//   h_total, h_active    measured line geometry
//   v_total, v_active    measured frame geometry
//   h_sync_w, v_sync_w   measured sync widths (constant 0 unless SYNC_WIDTH_MEASURE_EN)
//   frame_start          one-cycle pulse per vsync assertion
//   locked, err          lock status and one-cycle mismatch/timeout pulse
// Optional feature macro: SYNC_WIDTH_MEASURE_EN
module video_timing_detector #(
    parameter int H_RES        = 800,
    parameter int V_RES        = 525,
    parameter int X_RES        = 640,
    parameter int Y_RES        = 480,
    parameter int H_SYNC_WIDTH = 96,
    parameter int V_SYNC_WIDTH = 2,
    parameter int LOCK_FRAMES  = 2,
    parameter int CW           = 12
) (
    input  logic          clk_pix,
    input  logic          rst,
    input  logic          hsync,
    input  logic          vsync,
    input  logic          de,
    output logic          de_o,
    output logic [CW-1:0] sx,
    output logic [CW-1:0] sy,
    output logic [CW-1:0] h_total,
    output logic [CW-1:0] h_active,
    output logic [CW-1:0] v_total,
    output logic [CW-1:0] v_active,
    output logic [CW-1:0] h_sync_w,
    output logic [CW-1:0] v_sync_w,
    output logic          frame_start,
    output logic          locked,
    output logic          err
);
    typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_LOCKED} state_t;

    localparam logic [CW-1:0] CMAX   = {CW{1'b1}};
    localparam logic [CW-1:0] H_EXP  = CW'(H_RES);
    localparam logic [CW-1:0] X_EXP  = CW'(X_RES);
    localparam logic [CW-1:0] V_EXP  = CW'(V_RES);
    localparam logic [CW-1:0] Y_EXP  = CW'(Y_RES);
    localparam logic [CW-1:0] L_EXP  = CW'(LOCK_FRAMES);
    localparam logic [CW-1:0] TO_LIM = CW'(2 * H_RES - 1);

    function automatic logic [CW-1:0] inc_sat(input logic [CW-1:0] v);
        return (v == CMAX) ? v : v + 1'b1;
    endfunction

    logic          hs_q, vs_q, de_q, hs_q2, vs_q2, de_q2;
    logic          hs_edge, vs_edge, de_rise, de_fall;
    logic          sy_first, h_valid, frame_bad, line_bad, timeout, mismatch, sync_bad;
    logic [CW-1:0] h_cnt, de_cnt, line_cnt, act_cnt, match_cnt, match_n;
    logic          err_n, locked_n;
    state_t        state, state_n;

    assign hs_edge = hs_q2 & ~hs_q;
    assign vs_edge = vs_q2 & ~vs_q;
    assign de_rise = de_q & ~de_q2;
    assign de_fall = de_q2 & ~de_q;
    assign de_o    = de_q;

    // Position is updated on the same edge that loads de_q, so sx/sy line up with de_o.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            hs_q <= 1'b0; vs_q <= 1'b0; de_q <= 1'b0;
            hs_q2 <= 1'b0; vs_q2 <= 1'b0; de_q2 <= 1'b0;
            sx <= '0; sy <= '0; sy_first <= 1'b0;
        end else begin
            hs_q <= hsync; vs_q <= vsync; de_q <= de;
            hs_q2 <= hs_q; vs_q2 <= vs_q; de_q2 <= de_q;
            if (de && !de_q) begin
                sx <= '0;
                sy <= sy_first ? '0 : inc_sat(sy);
            end else if (de) begin
                sx <= inc_sat(sx);
            end
            if (vs_edge) sy_first <= 1'b1;
            else if (de && !de_q) sy_first <= 1'b0;
        end
    end

    // A single bad line anywhere in the frame must fail the frame compare, even
    // though h_total/h_active are overwritten by later good lines.
    assign line_bad = (hs_edge && h_valid && inc_sat(h_cnt) != H_EXP) ||
                      (de_fall && de_cnt != X_EXP);
    assign timeout  = !hs_edge && (h_cnt == TO_LIM);

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            h_cnt <= '0; h_valid <= 1'b0; h_total <= '0;
            de_cnt <= '0; h_active <= '0;
            line_cnt <= '0; v_total <= '0; act_cnt <= '0; v_active <= '0;
            frame_bad <= 1'b0;
        end else begin
            if (hs_edge) begin
                if (h_valid) h_total <= inc_sat(h_cnt);
                h_cnt   <= '0;
                h_valid <= 1'b1;
            end else begin
                h_cnt <= inc_sat(h_cnt);
                if (timeout) h_valid <= 1'b0;
            end
            if (de_rise) de_cnt <= {{(CW-1){1'b0}}, 1'b1};
            else if (de_q) de_cnt <= inc_sat(de_cnt);
            if (de_fall) h_active <= de_cnt;
            // Coincident hsync edge / de rise belong to the frame that is starting.
            if (vs_edge) begin
                v_total   <= line_cnt;
                line_cnt  <= {{(CW-1){1'b0}}, hs_edge};
                v_active  <= act_cnt;
                act_cnt   <= {{(CW-1){1'b0}}, de_rise};
                frame_bad <= line_bad;
            end else begin
                if (hs_edge) line_cnt <= inc_sat(line_cnt);
                if (de_rise) act_cnt <= inc_sat(act_cnt);
                if (line_bad) frame_bad <= 1'b1;
            end
        end
    end

`ifdef SYNC_WIDTH_MEASURE_EN
    logic [CW-1:0] hsw_cnt, vsw_cnt;
    logic          hs_rise, vs_rise;
    assign hs_rise = hs_q & ~hs_q2;
    assign vs_rise = vs_q & ~vs_q2;

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            hsw_cnt <= '0; vsw_cnt <= '0; h_sync_w <= '0; v_sync_w <= '0;
        end else begin
            if (hs_edge) hsw_cnt <= {{(CW-1){1'b0}}, 1'b1};
            else if (!hs_q) hsw_cnt <= inc_sat(hsw_cnt);
            if (hs_rise) h_sync_w <= hsw_cnt;
            if (vs_edge) vsw_cnt <= {{(CW-1){1'b0}}, hs_edge};
            else if (!vs_q && hs_edge) vsw_cnt <= inc_sat(vsw_cnt);
            if (vs_rise) v_sync_w <= vsw_cnt;
        end
    end
    assign sync_bad = (h_sync_w != CW'(H_SYNC_WIDTH)) || (v_sync_w != CW'(V_SYNC_WIDTH));
`else
    assign h_sync_w = '0;
    assign v_sync_w = '0;
    assign sync_bad = 1'b0;
    // Sync widths are not measured in this build; the parameters are referenced
    // here only so every build accepts the same parameter set.
    if (H_SYNC_WIDTH < 0 || V_SYNC_WIDTH < 0) begin : g_sync_params_unused
    end
`endif

    assign mismatch = frame_bad || sync_bad ||
                      (h_total != H_EXP) || (h_active != X_EXP) ||
                      (line_cnt != V_EXP) || (act_cnt != Y_EXP);

    always_comb begin
        state_n = state;
        match_n = match_cnt;
        err_n   = 1'b0;
        if (timeout) begin
            state_n = S_IDLE;
            match_n = '0;
            err_n   = 1'b1;
        end else if (vs_edge) begin
            case (state)
                S_IDLE: state_n = S_MEASURE;
                S_MEASURE, S_LOCKED: begin
                    if (mismatch) begin
                        err_n   = 1'b1;
                        match_n = '0;
                        state_n = S_MEASURE;
                    end else begin
                        match_n = inc_sat(match_cnt);
                        if (state == S_MEASURE && match_n >= L_EXP) state_n = S_LOCKED;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
        locked_n = (state_n == S_LOCKED);
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            state <= S_IDLE; match_cnt <= '0;
            err <= 1'b0; locked <= 1'b0; frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            match_cnt   <= match_n;
            err         <= err_n;
            locked      <= locked_n;
            frame_start <= vs_edge;
        end
    end
endmodule

// File: tb/tb_video_timing_detector.sv
// tb/tb_video_timing_detector.sv - self-checking bench for video_timing_detector on a scaled-down mode
module tb_video_timing_detector;
    localparam int H_RES = 50, X_RES = 32, HFP = 4, HSW = 6;
    localparam int V_RES = 20, Y_RES = 12, VFP = 2, VSW = 2;
    localparam int LOCK_FRAMES = 2, CW = 12;

    logic          clk_pix = 1'b0;
    logic          rst, hsync, vsync, de;
    logic          de_o, frame_start, locked, err;
    logic [CW-1:0] sx, sy, h_total, h_active, v_total, v_active, h_sync_w, v_sync_w;

    video_timing_detector #(
        .H_RES(H_RES), .V_RES(V_RES), .X_RES(X_RES), .Y_RES(Y_RES),
        .H_SYNC_WIDTH(HSW), .V_SYNC_WIDTH(VSW), .LOCK_FRAMES(LOCK_FRAMES), .CW(CW)
    ) dut (
        .clk_pix(clk_pix), .rst(rst), .hsync(hsync), .vsync(vsync), .de(de),
        .de_o(de_o), .sx(sx), .sy(sy), .h_total(h_total), .h_active(h_active),
        .v_total(v_total), .v_active(v_active), .h_sync_w(h_sync_w), .v_sync_w(v_sync_w),
        .frame_start(frame_start), .locked(locked), .err(err)
    );

    always #5 clk_pix = ~clk_pix;

    typedef struct {int px; int py; int due;} pix_t;
    pix_t pq[$];
    pix_t mon_p;

    int checks = 0, errors = 0;
    int cyc = 0, err_seen = 0, fs_seen = 0, last_hs_fall = 0, err_since = -1;
    bit sy_known = 1'b0;

    always @(posedge clk_pix) cyc++;

    // Scoreboard: each driven active pixel is due on de_o one clock later.
    always @(negedge clk_pix) begin
        if (err === 1'b1) begin
            err_seen++;
            err_since = cyc - last_hs_fall;
        end
        if (frame_start === 1'b1) fs_seen++;
        if (pq.size() > 0 && pq[0].due == cyc) begin
            mon_p = pq.pop_front();
            checks++;
            if (de_o !== 1'b1 || sx !== CW'(mon_p.px) || sy !== CW'(mon_p.py)) begin
                errors++;
                $display("FAIL pixel: de_o=%0b sx=%0d sy=%0d, expected de_o=1 sx=%0d sy=%0d",
                         de_o, sx, sy, mon_p.px, mon_p.py);
            end
        end
    end

    task automatic drive_clk(input logic h, input logic v, input logic d, input int px, input int py);
        @(posedge clk_pix);
        #1;
        if (!h && hsync) last_hs_fall = cyc;
        hsync = h; vsync = v; de = d;
        if (d && sy_known) pq.push_back('{px, py, cyc + 1});
        if (!v) sy_known = 1'b1;
    endtask

    task automatic drive_line(input int ln, input int n_active, input int hs_w, input int extra);
        for (int x = 0; x < H_RES + extra; x++)
            drive_clk(!(x >= X_RES + HFP && x < X_RES + HFP + hs_w),
                      !(ln >= Y_RES + VFP && ln < Y_RES + VFP + VSW),
                      (ln < n_active) && (x < X_RES), x, ln);
    endtask

    task automatic drive_frame(input int n_active, input int hs_w, input int stretch_line);
        for (int ln = 0; ln < V_RES; ln++)
            drive_line(ln, n_active, hs_w, (ln == stretch_line) ? 1 : 0);
    endtask

    task automatic test_reset();
        rst = 1'b1; hsync = 1'b1; vsync = 1'b1; de = 1'b0;
        repeat (4) @(posedge clk_pix);
        @(negedge clk_pix);
        checks++;
        if ({de_o, frame_start, locked, err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: de_o=%0b fs=%0b locked=%0b err=%0b, expected all 0",
                     de_o, frame_start, locked, err);
        end
        checks++;
        if ((sx | sy | h_total | h_active | v_total | v_active | h_sync_w | v_sync_w) !== '0) begin
            errors++;
            $display("FAIL reset_values: sx=%0d sy=%0d ht=%0d ha=%0d vt=%0d va=%0d, expected 0",
                     sx, sy, h_total, h_active, v_total, v_active);
        end
        @(posedge clk_pix);
        #1 rst = 1'b0;
    endtask

    task automatic test_ideal_lock();
        int e0 = err_seen, f0 = fs_seen;
        drive_frame(Y_RES, HSW, -1);
        drive_frame(Y_RES, HSW, -1);
        @(negedge clk_pix);
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL early_lock: locked=%0b, expected 0", locked); end
        drive_frame(Y_RES, HSW, -1);
        @(negedge clk_pix);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL ideal_lock: locked=%0b, expected 1", locked); end
        checks++;
        if (h_total !== CW'(H_RES) || h_active !== CW'(X_RES) || v_total !== CW'(V_RES) || v_active !== CW'(Y_RES)) begin
            errors++;
            $display("FAIL geometry: ht=%0d ha=%0d vt=%0d va=%0d, expected %0d %0d %0d %0d",
                     h_total, h_active, v_total, v_active, H_RES, X_RES, V_RES, Y_RES);
        end
        checks++;
        if (fs_seen - f0 != 3 || err_seen - e0 != 0) begin
            errors++;
            $display("FAIL pulses: frame_start=%0d err=%0d, expected 3 and 0", fs_seen - f0, err_seen - e0);
        end
        checks++;
`ifdef SYNC_WIDTH_MEASURE_EN
        if (h_sync_w !== CW'(HSW) || v_sync_w !== CW'(VSW)) begin
            errors++;
            $display("FAIL sync_w: h=%0d v=%0d, expected %0d %0d", h_sync_w, v_sync_w, HSW, VSW);
        end
`else
        if (h_sync_w !== '0 || v_sync_w !== '0) begin
            errors++;
            $display("FAIL sync_w: h=%0d v=%0d, expected 0 0", h_sync_w, v_sync_w);
        end
`endif
    endtask

    task automatic test_stretched_line();
        int e0 = err_seen;
        drive_frame(Y_RES, HSW, 0);
        @(negedge clk_pix);
        checks++;
        if (err_seen - e0 != 1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL stretch_err: err pulses=%0d locked=%0b, expected 1 and 0", err_seen - e0, locked);
        end
        drive_frame(Y_RES, HSW, -1);
        drive_frame(Y_RES, HSW, -1);
        @(negedge clk_pix);
        checks++;
        if (locked !== 1'b1 || err_seen - e0 != 1) begin
            errors++;
            $display("FAIL stretch_relock: locked=%0b err pulses=%0d, expected 1 and 1", locked, err_seen - e0);
        end
    endtask

    task automatic test_timeout();
        int e0 = err_seen;
        err_since = -1;
        repeat (2 * H_RES + 20) drive_clk(1'b1, 1'b1, 1'b0, 0, 0);
        @(negedge clk_pix);
        checks++;
        if (err_seen - e0 != 1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err: err pulses=%0d locked=%0b, expected 1 and 0", err_seen - e0, locked);
        end
        checks++;
        if (err_since < 2 * H_RES || err_since > 2 * H_RES + 2) begin
            errors++;
            $display("FAIL timeout_time: err %0d clocks after hsync fall, expected %0d..%0d",
                     err_since, 2 * H_RES, 2 * H_RES + 2);
        end
        drive_frame(Y_RES, HSW, -1);
        drive_frame(Y_RES, HSW, -1);
        @(negedge clk_pix);
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL timeout_idle: locked=%0b, expected 0", locked); end
        drive_frame(Y_RES, HSW, -1);
        @(negedge clk_pix);
        checks++;
        if (locked !== 1'b1 || err_seen - e0 != 1) begin
            errors++;
            $display("FAIL timeout_relock: locked=%0b err pulses=%0d, expected 1 and 1", locked, err_seen - e0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int e0;
        for (int ln = 0; ln <= 6; ln++) drive_line(ln, Y_RES, HSW, 0);
        @(negedge clk_pix);
        checks++;
        if (sy !== CW'(6) || locked !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: sy=%0d locked=%0b, expected 6 and 1", sy, locked);
        end
        @(posedge clk_pix);
        #1 rst = 1'b1;
        sy_known = 1'b0;
        pq.delete();
        @(posedge clk_pix);
        #1 rst = 1'b0;
        @(negedge clk_pix);
        checks++;
        if ({de_o, frame_start, locked, err} !== 4'b0 ||
            (sx | sy | h_total | h_active | v_total | v_active) !== '0) begin
            errors++;
            $display("FAIL mid_reset: locked=%0b sx=%0d sy=%0d ht=%0d va=%0d, expected all 0",
                     locked, sx, sy, h_total, v_active);
        end
        e0 = err_seen;
        for (int ln = 7; ln < V_RES; ln++) drive_line(ln, Y_RES, HSW, 0);
        drive_frame(Y_RES, HSW, -1);
        @(negedge clk_pix);
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL reset_early_lock: locked=%0b, expected 0", locked); end
        drive_frame(Y_RES, HSW, -1);
        @(negedge clk_pix);
        checks++;
        if (locked !== 1'b1 || err_seen != e0) begin
            errors++;
            $display("FAIL reset_relock: locked=%0b err pulses=%0d, expected 1 and 0", locked, err_seen - e0);
        end
    endtask

    task automatic test_short_active();
        int e0 = err_seen;
        drive_frame(Y_RES - 1, HSW, -1);
        @(negedge clk_pix);
        checks++;
        if (v_active !== CW'(Y_RES - 1) || err_seen - e0 != 1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL short_active: v_active=%0d err pulses=%0d locked=%0b, expected %0d 1 0",
                     v_active, err_seen - e0, locked, Y_RES - 1);
        end
        drive_frame(Y_RES, HSW, -1);
        @(negedge clk_pix);
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL short_match_clear: locked=%0b, expected 0", locked); end
        drive_frame(Y_RES, HSW, -1);
        @(negedge clk_pix);
        checks++;
        if (locked !== 1'b1 || err_seen - e0 != 1) begin
            errors++;
            $display("FAIL short_relock: locked=%0b err pulses=%0d, expected 1 and 1", locked, err_seen - e0);
        end
    endtask

`ifdef SYNC_WIDTH_MEASURE_EN
    task automatic test_sync_width();
        int e0 = err_seen;
        for (int f = 0; f < 3; f++) drive_frame(Y_RES, HSW - 1, -1);
        @(negedge clk_pix);
        checks++;
        if (h_sync_w !== CW'(HSW - 1) || err_seen - e0 != 3 || locked !== 1'b0) begin
            errors++;
            $display("FAIL sync_narrow: h_sync_w=%0d err pulses=%0d locked=%0b, expected %0d 3 0",
                     h_sync_w, err_seen - e0, locked, HSW - 1);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; hsync = 1'b1; vsync = 1'b1; de = 1'b0;
        test_reset();
        test_ideal_lock();
        test_stretched_line();
        test_timeout();
        test_reset_mid_frame();
        test_short_active();
`ifdef SYNC_WIDTH_MEASURE_EN
        test_sync_width();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/video_timing_detector.md
Name: video_timing_detector

Overview:
Sink-side counterpart of the display timing generator. It observes a pixel-clock-domain hsync/vsync/de stream, recovers pixel and line position, and measures line and frame geometry. It compares the measured geometry against the expected mode and reports lock. It sits after the video source or capture front end and ahead of any consumer that needs sx/sy or a "valid mode" qualifier.

Parameters:
H_RES, 800, expected total clocks per line
V_RES, 525, expected total lines per frame
X_RES, 640, expected active pixels per line
Y_RES, 480, expected active lines per frame
H_SYNC_WIDTH, 96, expected hsync width in clocks (optional feature only)
V_SYNC_WIDTH, 2, expected vsync width in lines (optional feature only)
LOCK_FRAMES, 2, consecutive matching frames required to assert locked
CW, 12, width of all counters and measurement outputs

Ports:
clk_pix  in  1  pixel clock
rst  in  1  reset: synchronous, active-high
hsync  in  1  horizontal sync, active-low
vsync  in  1  vertical sync, active-low
de  in  1  data enable, high in active area
de_o  out  1  de delayed to align with sx/sy
sx  out  CW  recovered horizontal position, valid while de_o=1
sy  out  CW  recovered active-line index, valid while de_o=1
h_total  out  CW  measured clocks between hsync assertions
h_active  out  CW  measured de-high clocks in last active line
v_total  out  CW  measured hsync assertions per frame
v_active  out  CW  measured active lines per frame
h_sync_w  out  CW  measured hsync width (optional feature)
v_sync_w  out  CW  measured vsync width in lines (optional feature)
frame_start  out  1  one-cycle pulse on each vsync assertion
locked  out  1  geometry matches expected for LOCK_FRAMES frames
err  out  1  one-cycle pulse on mismatch or timeout

Behaviour:
- Inputs registered once (hs_q, vs_q, de_q); edge detect against a second stage. hs_edge = hsync 1->0, vs_edge = vsync 1->0, de_rise/de_fall on de_q.
- Reset: all outputs 0; all counters, match count, and valid flags 0.
- Latency: de_o = de_q, one clock after de; sx/sy aligned to de_o.
- sx: 0 on de_rise cycle, +1 each following cycle while de_q=1. Value undefined-but-held while de_o=0.
- sy: 0 on first de_rise after a vs_edge, +1 on each later de_rise. Saturates at 2^CW-1.
- h counter: +1 per clock. On hs_edge: h_total <= count+1 if h_valid, count <= 0, h_valid <= 1. First hs_edge after reset/timeout only starts the count.
- h_active: de-high clock count latched on de_fall.
- Line counter: +1 per hs_edge. On vs_edge: v_total <= line count; line count <= (hs_edge ? 1 : 0). A coincident hsync edge belongs to the new frame. v_active is latched from the de_rise count the same way.
- frame_start pulses on every vs_edge.
- Check state machine, 3 states:
  - IDLE: first vs_edge -> MEASURE, no compare.
  - MEASURE: each vs_edge compares h_total/h_active/v_total/v_active with H_RES/X_RES/V_RES/Y_RES.
    - All equal: match_cnt+1 (saturating); reaching LOCK_FRAMES -> LOCKED, locked=1 from the next cycle.
    - Any mismatch: err pulse, match_cnt <= 0.
  - LOCKED: same compare each frame; mismatch -> err pulse, locked <= 0, match_cnt <= 0, -> MEASURE.
- Timeout: clocks since last hs_edge reach 2*H_RES -> err pulse (once; counter saturates), locked <= 0, h_valid <= 0, -> IDLE. Measurements keep their last values.
- All counters saturate at 2^CW-1; no wrap.
- rst asserted mid-frame: everything returns to reset values on the next edge. Re-lock needs a full IDLE->MEASURE sequence.

Optional Feature:
SYNC_WIDTH_MEASURE_EN
- Defined: h_sync_w = clocks hsync low, latched on hsync 1->0->1 completion; v_sync_w = hs_edges counted while vsync low, latched on vsync rise. Both are added to the compare against H_SYNC_WIDTH/V_SYNC_WIDTH.
- Undefined: h_sync_w = v_sync_w = 0 constant, excluded from compare. Ports remain present.

Test Plan:
- Reset, then ideal 640x480p60 stream (800/525, hs 96 @656, vs 2 @490) -> locked=1 after 2nd compared vs_edge; h_total=800, h_active=640, v_total=525, v_active=480; first active pixel sx=0/sy=0, last sx=639/sy=479.
- Locked stream, one line stretched to 801 clocks -> err single pulse at next vs_edge, locked=0; two further good frames -> locked=1.
- Hold hsync high 1600 clocks while locked -> err pulse exactly once at clock 1600, locked=0, state IDLE; resume stream -> relock after 1+2 vs_edges.
- Assert rst for 1 cycle at mid-frame (sy=200) -> all outputs 0 next cycle; locked stays 0 until two full compared frames.
- Frame with 479 active lines -> v_active=479, err pulse, match_cnt cleared, locked=0.
- SYNC_WIDTH_MEASURE_EN defined, ideal stream -> h_sync_w=96, v_sync_w=2; hsync width 95 -> err, no lock.
